// File: rtl/branch_target_buffer.sv
// Fully-associative branch target buffer with 2-bit saturating direction counters,
// round-robin allocation on taken misses, and resolved-branch / correct-prediction counters.
module branch_target_buffer #(
   parameter int unsigned ENTRIES = 8,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             RST,
   input  logic [31:0]      pc_f,
   output logic             pred_taken,
   output logic [31:0]      pred_target,
   input  logic             upd_en,
   input  logic [31:0]      upd_pc,
   input  logic             upd_taken,
   input  logic [31:0]      upd_target,
   input  logic             upd_pred_taken,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] hit_cnt
);

   localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   logic [ENTRIES-1:0] valid;
   logic [29:0]        tag    [ENTRIES];
   logic [31:0]        target [ENTRIES];
   logic [1:0]         ctr    [ENTRIES];
   logic [IDX_W-1:0]   ptr;

   logic [ENTRIES-1:0] look_match;
   logic [ENTRIES-1:0] upd_match;
   logic [IDX_W-1:0]   look_idx;
   logic [IDX_W-1:0]   upd_idx;
   logic               look_hit;
   logic               upd_hit;

   // Tags are unique, so OR-ing the indices of matching entries yields the single match.
   always_comb begin
      look_match = '0;
      upd_match  = '0;
      look_idx   = '0;
      upd_idx    = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         look_match[i] = valid[i] && (tag[i] == pc_f[31:2]);
         upd_match[i]  = valid[i] && (tag[i] == upd_pc[31:2]);
         if (look_match[i]) look_idx = look_idx | IDX_W'(i);
         if (upd_match[i])  upd_idx  = upd_idx  | IDX_W'(i);
      end
      look_hit = |look_match;
      upd_hit  = |upd_match;
   end

   always_comb begin
      pred_taken  = look_hit && ctr[look_idx][1];
      pred_target = pred_taken ? target[look_idx] : '0;
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         valid   <= '0;
         ptr     <= '0;
         br_cnt  <= '0;
         hit_cnt <= '0;
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            ctr[i] <= 2'b00;
         end
      end else if (upd_en) begin
         br_cnt <= br_cnt + 1'b1;
         if (upd_taken == upd_pred_taken) begin
            hit_cnt <= hit_cnt + 1'b1;
         end
         if (upd_hit) begin
            if (upd_taken) begin
               target[upd_idx] <= upd_target;
               if (ctr[upd_idx] != 2'b11) ctr[upd_idx] <= ctr[upd_idx] + 2'b01;
            end else begin
               if (ctr[upd_idx] != 2'b00) ctr[upd_idx] <= ctr[upd_idx] - 2'b01;
            end
         end else if (upd_taken) begin
            valid[ptr]  <= 1'b1;
            tag[ptr]    <= upd_pc[31:2];
            target[ptr] <= upd_target;
            ctr[ptr]    <= 2'b10;
            ptr         <= (ptr == IDX_W'(ENTRIES - 1)) ? '0 : ptr + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed-vector bench for branch_target_buffer: allocation, counter hysteresis,
// no-allocate on not-taken misses, round-robin replacement, same-cycle visibility.
module tb_branch_target_buffer;

   localparam int unsigned ENTRIES = 8;
   localparam int unsigned CNT_W   = 16;

   logic             clk = 1'b0;
   logic             RST = 1'b0;
   logic [31:0]      pc_f = '0;
   logic             pred_taken;
   logic [31:0]      pred_target;
   logic             upd_en = 1'b0;
   logic [31:0]      upd_pc = '0;
   logic             upd_taken = 1'b0;
   logic [31:0]      upd_target = '0;
   logic             upd_pred_taken = 1'b0;
   logic [CNT_W-1:0] br_cnt;
   logic [CNT_W-1:0] hit_cnt;

   int vectors = 0;
   int miscompares = 0;

   branch_target_buffer #(.ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
      .clk(clk), .RST(RST), .pc_f(pc_f), .pred_taken(pred_taken), .pred_target(pred_target),
      .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_pred_taken(upd_pred_taken), .br_cnt(br_cnt), .hit_cnt(hit_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic pr);
      upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_pred_taken = pr; upd_en = 1'b1;
      step();
      upd_en = 1'b0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      step();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      pc_f = 32'h0; #1;
      vectors++;
      if (pred_taken !== 1'b0) begin
         miscompares++; $display("FAIL reset_pt0 got=%b exp=0", pred_taken);
      end
      pc_f = 32'h40; #1;
      vectors++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
         miscompares++; $display("FAIL reset_pt40 got=%b/%h exp=0/0", pred_taken, pred_target);
      end
      vectors++;
      if (br_cnt !== '0 || hit_cnt !== '0) begin
         miscompares++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", br_cnt, hit_cnt);
      end
   endtask

   task automatic test_allocate();
      upd(32'h100, 1'b1, 32'h200, 1'b0);
      pc_f = 32'h100; #1;
      vectors++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
         miscompares++; $display("FAIL alloc_hit got=%b/%h exp=1/00000200", pred_taken, pred_target);
      end
      pc_f = 32'h103; #1;
      vectors++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
         miscompares++; $display("FAIL alloc_lowbits got=%b/%h exp=1/00000200", pred_taken, pred_target);
      end
      pc_f = 32'h104; #1;
      vectors++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
         miscompares++; $display("FAIL alloc_neighbour got=%b/%h exp=0/0", pred_taken, pred_target);
      end
      vectors++;
      if (br_cnt !== 16'd1 || hit_cnt !== 16'd0) begin
         miscompares++; $display("FAIL alloc_cnt got=%0d/%0d exp=1/0", br_cnt, hit_cnt);
      end
   endtask

   task automatic check_pt(input string name, input logic exp_pt, input logic [31:0] exp_tgt);
      pc_f = 32'h100; #1;
      vectors++;
      if (pred_taken !== exp_pt || pred_target !== exp_tgt) begin
         miscompares++;
         $display("FAIL %s got=%b/%h exp=%b/%h", name, pred_taken, pred_target, exp_pt, exp_tgt);
      end
   endtask

   task automatic test_hysteresis();
      upd(32'h100, 1'b0, 32'h0,   1'b1);  check_pt("hyst_01", 1'b0, 32'h0);
      upd(32'h100, 1'b1, 32'h280, 1'b0);  check_pt("hyst_10", 1'b1, 32'h280);
      upd(32'h100, 1'b1, 32'h280, 1'b1);
      upd(32'h100, 1'b1, 32'h280, 1'b1);
      upd(32'h100, 1'b0, 32'h999, 1'b1);  check_pt("hyst_sat11", 1'b1, 32'h280);
      upd(32'h100, 1'b0, 32'h0,   1'b1);
      upd(32'h100, 1'b0, 32'h0,   1'b0);
      upd(32'h100, 1'b0, 32'h0,   1'b0);  check_pt("hyst_00", 1'b0, 32'h0);
      upd(32'h100, 1'b1, 32'h2C0, 1'b0);  check_pt("hyst_sat00", 1'b0, 32'h0);
      upd(32'h100, 1'b1, 32'h2C0, 1'b0);  check_pt("hyst_back", 1'b1, 32'h2C0);
      vectors++;
      if (br_cnt !== 16'd11 || hit_cnt !== 16'd4) begin
         miscompares++; $display("FAIL hyst_cnt got=%0d/%0d exp=11/4", br_cnt, hit_cnt);
      end
   endtask

   // Allocation pointer must not move on a not-taken miss: with 0x0 in entry 0 and the
   // miss in between, 0x20 must land in entry 0 and evict only 0x0.
   task automatic test_no_alloc_replacement();
      do_reset();
      upd(32'h0, 1'b1, 32'h1000, 1'b0);
      upd(32'h300, 1'b0, 32'h0, 1'b0);
      pc_f = 32'h300; #1;
      vectors++;
      if (pred_taken !== 1'b0) begin
         miscompares++; $display("FAIL noalloc_pt got=%b exp=0", pred_taken);
      end
      for (int a = 4; a <= 32'h20; a += 4) upd(32'(a), 1'b1, 32'(a) + 32'h1000, 1'b0);
      pc_f = 32'h0; #1;
      vectors++;
      if (pred_taken !== 1'b0) begin
         miscompares++; $display("FAIL evict_0 got=%b exp=0", pred_taken);
      end
      for (int a = 4; a <= 32'h20; a += 4) begin
         pc_f = 32'(a); #1;
         vectors++;
         if (pred_taken !== 1'b1 || pred_target !== 32'(a) + 32'h1000) begin
            miscompares++;
            $display("FAIL repl_keep pc=%h got=%b/%h exp=1/%h", a, pred_taken, pred_target, 32'(a) + 32'h1000);
         end
      end
      vectors++;
      if (br_cnt !== 16'd10 || hit_cnt !== 16'd1) begin
         miscompares++; $display("FAIL repl_cnt got=%0d/%0d exp=10/1", br_cnt, hit_cnt);
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      @(negedge clk);
      pc_f = 32'h500; upd_pc = 32'h500; upd_taken = 1'b1; upd_target = 32'h600;
      upd_pred_taken = 1'b0; upd_en = 1'b1;
      #1;
      vectors++;
      if (pred_taken !== 1'b0) begin
         miscompares++; $display("FAIL same_cycle_before got=%b exp=0", pred_taken);
      end
      step();
      upd_en = 1'b0; #1;
      vectors++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h600) begin
         miscompares++; $display("FAIL same_cycle_after got=%b/%h exp=1/00000600", pred_taken, pred_target);
      end
      RST = 1'b1;
      upd_pc = 32'h700; upd_taken = 1'b1; upd_target = 32'h800; upd_en = 1'b1;
      step();
      RST = 1'b0; upd_en = 1'b0;
      pc_f = 32'h700; #1;
      vectors++;
      if (pred_taken !== 1'b0) begin
         miscompares++; $display("FAIL rst_over_upd got=%b exp=0", pred_taken);
      end
      pc_f = 32'h500; #1;
      vectors++;
      if (pred_taken !== 1'b0 || br_cnt !== '0 || hit_cnt !== '0) begin
         miscompares++; $display("FAIL rst_clear got=%b/%0d/%0d exp=0/0/0", pred_taken, br_cnt, hit_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_allocate();
      test_hysteresis();
      test_no_alloc_replacement();
      test_same_cycle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
